// File: rtl/axi_mem_resp.sv
// AXI4 subordinate that terminates bursts in an internal flop-array memory; separate read and write engines.
// WRAP bursts are supported only when AXI_MEM_RESP_WRAP_EN is defined; otherwise they answer SLVERR.
module axi_mem_resp #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned NumWords   = 256,
    parameter type axi_req_t  = logic [2*IdWidth+2*AddrWidth+DataWidth+DataWidth/8+73-1:0],
    parameter type axi_resp_t = logic [2*IdWidth+DataWidth+12-1:0]
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OB        = $clog2(StrbWidth);
    localparam int unsigned IW        = $clog2(NumWords);
`ifdef AXI_MEM_RESP_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif
    localparam logic [1:0] BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2;
    localparam logic [1:0] RESP_OKAY = 2'd0, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic                 user;
    } aw_chan_t;
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic                 user;
    } ar_chan_t;
    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic                 user;
    } w_chan_t;
    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
        logic               user;
    } b_chan_t;
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic                 user;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic addr_decerr(input logic [AddrWidth-1:0] addr);
        return (addr >> (OB + IW)) != '0;
    endfunction

    function automatic logic burst_unsup(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
        if (32'(size) > OB) return 1'b1;
        case (burst)
            BURST_FIXED, BURST_INCR: return 1'b0;
            BURST_WRAP: return WrapEn ? !(len inside {8'd1, 8'd3, 8'd7, 8'd15}) : 1'b1;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
        logic [AddrWidth-1:0] step, incr, wbytes, lower;
        step   = AddrWidth'(1) << size;
        incr   = (addr & ~(step - AddrWidth'(1))) + step;
        wbytes = (AddrWidth'(len) + AddrWidth'(1)) << size;
        lower  = addr & ~(wbytes - AddrWidth'(1));
        case (burst)
            BURST_INCR: return incr;
            BURST_WRAP: return !WrapEn ? addr : ((incr == lower + wbytes) ? lower : incr);
            default:    return addr;
        endcase
    endfunction

    req_t  req;
    resp_t resp;
    assign req        = req_t'(slv_req_i);
    assign slv_resp_o = axi_resp_t'(resp);

    logic [DataWidth-1:0] mem [NumWords];

    w_state_e             w_state, w_state_n;
    logic [IdWidth-1:0]   w_id;
    logic [AddrWidth-1:0] w_addr;
    logic [7:0]           w_len, w_cnt;
    logic [2:0]           w_size;
    logic [1:0]           w_burst;
    logic                 w_unsup, w_decerr;
    logic                 aw_hs, w_hs;

    r_state_e             r_state, r_state_n;
    logic [IdWidth-1:0]   r_id;
    logic [AddrWidth-1:0] r_addr, rd_addr;
    logic [7:0]           r_len, r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst, r_resp, rd_resp;
    logic                 r_unsup, r_last, rd_unsup, rd_dec;
    logic [DataWidth-1:0] r_data, rd_word;
    logic                 ar_hs, r_hs;

    assign aw_hs = req.aw_valid && (w_state == W_IDLE);
    assign w_hs  = req.w_valid && (w_state == W_DATA);
    assign ar_hs = req.ar_valid && (r_state == R_IDLE);
    assign r_hs  = req.r_ready && (r_state == R_DATA);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        r_state_n = r_state;
        resp      = '0;
        resp.aw_ready = (w_state == W_IDLE);
        resp.w_ready  = (w_state == W_DATA);
        resp.b_valid  = (w_state == W_RESP);
        resp.b.id     = w_id;
        resp.b.resp   = w_decerr ? RESP_DECERR : (w_unsup ? RESP_SLVERR : RESP_OKAY);
        resp.ar_ready = (r_state == R_IDLE);
        resp.r_valid  = (r_state == R_DATA);
        resp.r.id     = r_id;
        resp.r.data   = r_data;
        resp.r.resp   = r_resp;
        resp.r.last   = r_last;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_n = W_DATA;
            W_DATA:  if (w_hs && w_cnt == w_len) w_state_n = W_RESP;
            W_RESP:  if (req.b_ready) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_n = R_DATA;
            R_DATA:  if (r_hs && r_last) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
            w_size <= '0; w_burst <= '0; w_unsup <= 1'b0; w_decerr <= 1'b0;
        end else if (aw_hs) begin
            w_id     <= req.aw.id;
            w_addr   <= req.aw.addr;
            w_len    <= req.aw.len;
            w_size   <= req.aw.size;
            w_burst  <= req.aw.burst;
            w_cnt    <= '0;
            w_unsup  <= burst_unsup(req.aw.size, req.aw.burst, req.aw.len);
            w_decerr <= 1'b0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
            w_cnt  <= w_cnt + 8'd1;
            if (addr_decerr(w_addr)) w_decerr <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem <= '{default: '0};
        end else if (w_hs && !w_unsup && !addr_decerr(w_addr)) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (req.w.strb[b]) mem[w_addr[OB+IW-1:OB]][8*b +: 8] <= req.w.data[8*b +: 8];
            end
        end
    end

    // Read payload is registered from the address of the beat about to be presented, so a
    // same-cycle write is seen only by later beats and a stalled beat cannot change.
    always_comb begin
        rd_addr  = ar_hs ? req.ar.addr : next_addr(r_addr, r_size, r_burst, r_len);
        rd_unsup = ar_hs ? burst_unsup(req.ar.size, req.ar.burst, req.ar.len) : r_unsup;
        rd_dec   = addr_decerr(rd_addr);
        rd_word  = (rd_dec || rd_unsup) ? '0 : mem[rd_addr[OB+IW-1:OB]];
        rd_resp  = rd_dec ? RESP_DECERR : (rd_unsup ? RESP_SLVERR : RESP_OKAY);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0;
            r_burst <= '0; r_unsup <= 1'b0; r_last <= 1'b0; r_data <= '0; r_resp <= '0;
        end else if (ar_hs) begin
            r_id    <= req.ar.id;
            r_addr  <= rd_addr;
            r_len   <= req.ar.len;
            r_size  <= req.ar.size;
            r_burst <= req.ar.burst;
            r_unsup <= rd_unsup;
            r_cnt   <= '0;
            r_last  <= (req.ar.len == 8'd0);
            r_data  <= rd_word;
            r_resp  <= rd_resp;
        end else if (r_hs && !r_last) begin
            r_addr <= rd_addr;
            r_cnt  <= r_cnt + 8'd1;
            r_last <= (r_cnt + 8'd1 == r_len);
            r_data <= rd_word;
            r_resp <= rd_resp;
        end
    end

    logic unused_fields;
    assign unused_fields = ^{req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region,
                             req.aw.atop, req.aw.user, req.w.last, req.w.user, req.ar.lock,
                             req.ar.cache, req.ar.prot, req.ar.qos, req.ar.region, req.ar.user};
endmodule
